// File: rtl/punc_debug_dumper.sv
// Debug-port sweeper for PUnC: snapshots PC, R0..R7 and a memory window,
// then streams each word out over a valid/ready channel with tag and index.
module punc_debug_dumper #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_count,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_debug_addr,
  output logic [2:0]  rf_debug_addr,
  input  logic [15:0] mem_debug_data,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_tag,
  output logic [15:0] out_index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_EMIT,
    S_FIN
  } state_t;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_RF  = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam logic [1:0] LAT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t      state;
  logic [1:0]  item;
  logic [15:0] base;
  logic [15:0] rem;
  logic [1:0]  wait_cnt;

  logic [15:0] cap_word;
  logic [15:0] cap_index;

  function automatic logic [15:0] pick_word(input logic [1:0]  kind,
                                            input logic [15:0] pc_w,
                                            input logic [15:0] rf_w,
                                            input logic [15:0] mem_w);
    case (kind)
      TAG_RF:  pick_word = rf_w;
      TAG_MEM: pick_word = mem_w;
      default: pick_word = pc_w;
    endcase
  endfunction

  function automatic logic [15:0] pick_index(input logic [1:0]  kind,
                                             input logic [2:0]  rf_a,
                                             input logic [15:0] mem_a);
    case (kind)
      TAG_RF:  pick_index = {13'd0, rf_a};
      TAG_MEM: pick_index = mem_a;
      default: pick_index = 16'd0;
    endcase
  endfunction

  // The address registers double as the item pointer, so the captured
  // index always matches exactly what was presented to the core.
  always_comb begin
    cap_word  = pick_word(item, pc_debug_data, rf_debug_data, mem_debug_data);
    cap_index = pick_index(item, rf_debug_addr, mem_debug_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      item           <= TAG_PC;
      base           <= 16'd0;
      rem            <= 16'd0;
      wait_cnt       <= 2'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= 16'd0;
      out_tag        <= 2'd0;
      out_index      <= 16'd0;
      mem_debug_addr <= 16'd0;
      rf_debug_addr  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base  <= mem_base;
            rem   <= mem_count;
            item  <= TAG_PC;
            busy  <= 1'b1;
            state <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (RD_LAT == 0) begin
            out_valid <= 1'b1;
            out_data  <= cap_word;
            out_tag   <= item;
            out_index <= cap_index;
            state     <= S_EMIT;
          end else begin
            wait_cnt <= LAT_LAST;
            state    <= S_WAIT;
          end
        end

        // Debug data is taken once, at the end of the last latency cycle.
        S_WAIT: begin
          if (wait_cnt == 2'd0) begin
            out_valid <= 1'b1;
            out_data  <= cap_word;
            out_tag   <= item;
            out_index <= cap_index;
            state     <= S_EMIT;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            case (item)
              TAG_PC: begin
                item          <= TAG_RF;
                rf_debug_addr <= 3'd0;
                state         <= S_ADDR;
              end
              TAG_RF: begin
                if (rf_debug_addr != 3'd7) begin
                  rf_debug_addr <= rf_debug_addr + 3'd1;
                  state         <= S_ADDR;
                end else if (rem == 16'd0) begin
                  done  <= 1'b1;
                  state <= S_FIN;
                end else begin
                  item           <= TAG_MEM;
                  mem_debug_addr <= base;
                  state          <= S_ADDR;
                end
              end
              default: begin
                // rem counts memory words not yet handed off, current included.
                rem <= rem - 16'd1;
                if (rem == 16'd1) begin
                  done  <= 1'b1;
                  state <= S_FIN;
                end else begin
                  mem_debug_addr <= mem_debug_addr + 16'd1;
                  state          <= S_ADDR;
                end
              end
            endcase
          end
        end

        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Directed bench for punc_debug_dumper with RD_LAT=1 against a one-cycle
// latency model of the PUnC debug port.
module tb_punc_debug_dumper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_base;
  logic [15:0] mem_count;
  logic        busy;
  logic        done;
  logic [15:0] mem_debug_addr;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_data;
  logic [15:0] rf_debug_data;
  logic [15:0] pc_debug_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic [15:0] out_index;

  int checks = 0;
  int errors = 0;

  punc_debug_dumper #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_base(mem_base), .mem_count(mem_count),
    .busy(busy), .done(done),
    .mem_debug_addr(mem_debug_addr), .rf_debug_addr(rf_debug_addr),
    .mem_debug_data(mem_debug_data), .rf_debug_data(rf_debug_data),
    .pc_debug_data(pc_debug_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_index(out_index)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h4000: mem_word = 16'hAAAA;
      16'h4001: mem_word = 16'h5555;
      16'hFFFF: mem_word = 16'hBEEF;
      16'h0000: mem_word = 16'h1234;
      16'h0001: mem_word = 16'h5678;
      default:  mem_word = 16'hDEAD;
    endcase
  endfunction

  // Core model: RF and memory answer one cycle after the address changes.
  assign pc_debug_data = 16'h3000;
  always @(posedge clk) begin
    mem_debug_data <= mem_word(mem_debug_addr);
    rf_debug_data  <= 16'h1110 + 16'(rf_debug_addr);
  end

  // Recorder: cycle 1 is the first cycle after the accepting edge.
  int          rel = 0;
  logic [1:0]  rec_tag[$];
  logic [15:0] rec_idx[$];
  logic [15:0] rec_data[$];
  int          rec_cyc[$];
  int          done_cnt = 0, done_cyc = 0;
  int          busy_cnt = 0, busy_first = 0, busy_last = 0;
  logic [15:0] addr_hold = 16'h0;
  logic        addr_moved = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (start && !busy && !rst) begin
      rel = 0;
      rec_tag.delete(); rec_idx.delete(); rec_data.delete(); rec_cyc.delete();
      done_cnt = 0; done_cyc = 0;
      busy_cnt = 0; busy_first = 0; busy_last = 0;
      addr_hold = mem_debug_addr;
      addr_moved = 1'b0;
    end else begin
      rel = rel + 1;
      if (out_valid && out_ready) begin
        rec_tag.push_back(out_tag);
        rec_idx.push_back(out_index);
        rec_data.push_back(out_data);
        rec_cyc.push_back(rel);
      end
      if (done) begin done_cnt = done_cnt + 1; done_cyc = rel; end
      if (busy) begin
        busy_cnt = busy_cnt + 1;
        if (busy_first == 0) busy_first = rel;
        busy_last = rel;
      end
      if (mem_debug_addr !== addr_hold) addr_moved = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_dump(input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    mem_base = b; mem_count = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_base = 16'h0BAD; mem_count = 16'h0007;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (done_cnt > 0) begin seen = 1; break; end
    end
    chk({nm, " done_seen"}, 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Expected stream; a 5-cycle stall on item 4 (R3) shifts items 4 onwards.
  task automatic check_stream(input string nm, input logic [15:0] b, input int cnt,
                              input int shift, input int done_exp);
    int n;
    logic [15:0] a;
    n = 9 + cnt;
    chk({nm, " len"}, 32'(rec_tag.size()), 32'(n));
    if (rec_tag.size() == n) begin
      for (int k = 0; k < n; k++) begin
        logic [1:0]  et;
        logic [15:0] ei, ed;
        int ec;
        if (k == 0) begin et = 2'd0; ei = 16'h0; ed = 16'h3000; end
        else if (k < 9) begin et = 2'd1; ei = 16'(k - 1); ed = 16'h1110 + 16'(k - 1); end
        else begin a = b + 16'(k - 9); et = 2'd2; ei = a; ed = mem_word(a); end
        ec = 3 * (k + 1) + ((k >= 4) ? shift : 0);
        chk($sformatf("%s tag%0d", nm, k),  32'(rec_tag[k]),  32'(et));
        chk($sformatf("%s idx%0d", nm, k),  32'(rec_idx[k]),  32'(ei));
        chk($sformatf("%s data%0d", nm, k), 32'(rec_data[k]), 32'(ed));
        chk($sformatf("%s cyc%0d", nm, k),  32'(rec_cyc[k]),  32'(ec));
      end
    end
    chk({nm, " done_cnt"}, 32'(done_cnt), 32'd1);
    chk({nm, " done_cyc"}, 32'(done_cyc), 32'(done_exp));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " busy"},      32'(busy),           32'd0);
    chk({nm, " done"},      32'(done),           32'd0);
    chk({nm, " out_valid"}, 32'(out_valid),      32'd0);
    chk({nm, " out_data"},  32'(out_data),       32'd0);
    chk({nm, " out_tag"},   32'(out_tag),        32'd0);
    chk({nm, " out_index"}, 32'(out_index),      32'd0);
    chk({nm, " mem_addr"},  32'(mem_debug_addr), 32'd0);
    chk({nm, " rf_addr"},   32'(rf_debug_addr),  32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    mem_base = 16'h0; mem_count = 16'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic dump
    start_dump(16'h4000, 16'd2);
    wait_done("basic");
    check_stream("basic", 16'h4000, 2, 0, 34);
    chk("basic busy_first", 32'(busy_first), 32'd1);
    chk("basic busy_last",  32'(busy_last),  32'd34);
    chk("basic busy_cnt",   32'(busy_cnt),   32'd34);

    // Backpressure on the R3 word
    start_dump(16'h4000, 16'd2);
    begin
      bit found = 0;
      for (int i = 0; i < 100; i++) begin
        if (out_valid && out_tag == 2'd1 && out_index == 16'd3) begin found = 1; break; end
        @(negedge clk);
      end
      chk("bp found_r3", 32'(found), 32'd1);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp data%0d", i),  32'(out_data),  32'h1113);
      chk($sformatf("bp index%0d", i), 32'(out_index), 32'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done("bp");
    check_stream("bp", 16'h4000, 2, 5, 39);

    // Zero count: memory address must stay at 0x4001 from the previous dump
    start_dump(16'h2222, 16'd0);
    wait_done("zero");
    check_stream("zero", 16'h2222, 0, 0, 28);
    chk("zero addr_moved", 32'(addr_moved), 32'd0);
    chk("zero mem_addr", 32'(mem_debug_addr), 32'h4001);

    // Wrap-around
    start_dump(16'hFFFF, 16'd3);
    wait_done("wrap");
    check_stream("wrap", 16'hFFFF, 3, 0, 37);

    // Start while busy is ignored
    start_dump(16'h4000, 16'd2);
    repeat (8) @(negedge clk);
    mem_base = 16'h1000; mem_count = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sbusy");
    repeat (10) @(negedge clk);
    check_stream("sbusy", 16'h4000, 2, 0, 34);
    chk("sbusy idle", 32'(busy), 32'd0);

    // Reset during the R5 WAIT cycle
    start_dump(16'h4000, 16'd2);
    begin
      bit found = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (busy && rf_debug_addr == 3'd5 && !out_valid) begin found = 1; break; end
      end
      chk("rst found_r5", 32'(found), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst mid");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_dump(16'h4000, 16'd2);
    wait_done("fresh");
    check_stream("fresh", 16'h4000, 2, 0, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
